// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C bus-condition detector:
//   - bus_state_e     : bus tracking state (idle / busy)
//   - I2C_SYNC_STAGES : default synchroniser depth per line
//   - I2C_FILT_LEN    : default number of stable samples before a line changes
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    localparam int I2C_SYNC_STAGES = 2;
    localparam int I2C_FILT_LEN    = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// ---------------------------------------------------------------------------
// i2c_line_filter
// Synchroniser plus stability filter for one open-drain I2C line. Both the
// chain and the filtered value reset to 1 (released bus).
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   i_line  in  raw pad value (asynchronous)
//   o_line  out synchronised, filtered line value (registered)
// ---------------------------------------------------------------------------
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_line
);

    // Counter only needs to reach FILT_LEN-1; the FILT_LEN-th differing
    // sample updates the filtered value instead of incrementing.
    localparam int              CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_line = r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (w_sync != r_filt) begin
            if (r_cnt == CNT_LAST) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            // Any sample agreeing with the filtered value restarts the run.
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/i2c_bus_cond_detector.sv
// ---------------------------------------------------------------------------
// i2c_bus_cond_detector
// Filters raw SCL/SDA and reports START, repeated START and STOP, tracks the
// bus-busy state, and optionally releases a bus left idle-high while busy.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   enable     in  detection enable (filters run regardless)
//   scl, sda   in  raw pad lines (asynchronous)
//   scl_f      out filtered SCL
//   sda_f      out filtered SDA
//   start      out 1-clk pulse, START seen while idle
//   rep_start  out 1-clk pulse, START seen while busy
//   stop       out 1-clk pulse, STOP seen
//   bus_busy   out level, state is BUSY
//   timeout    out 1-clk pulse, busy bus sat idle-high for IDLE_TIMEOUT clks
// ---------------------------------------------------------------------------
module i2c_bus_cond_detector
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES  = I2C_SYNC_STAGES,
    parameter int FILT_LEN     = I2C_FILT_LEN,
    parameter int IDLE_TIMEOUT = 0,
    parameter int TO_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic scl,
    input  logic sda,
    output logic scl_f,
    output logic sda_f,
    output logic start,
    output logic rep_start,
    output logic stop,
    output logic bus_busy,
    output logic timeout
);

    localparam logic            TO_EN   = (IDLE_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = (IDLE_TIMEOUT > 0) ? TO_W'(IDLE_TIMEOUT - 1) : '0;

    logic       w_scl_f, w_sda_f;
    logic       r_scl_p, r_sda_p;
    logic       w_start_cond, w_stop_cond, w_both_high, w_to_hit;
    logic [TO_W-1:0] r_to_cnt;
    bus_state_e r_state, w_state_nxt;
    logic       w_start_nxt, w_rep_nxt, w_stop_nxt, w_to_nxt;
    logic       r_start, r_rep, r_stop, r_to;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (scl),
        .o_line (w_scl_f)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (sda),
        .o_line (w_sda_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_p <= 1'b1;
            r_sda_p <= 1'b1;
        end else begin
            r_scl_p <= w_scl_f;
            r_sda_p <= w_sda_f;
        end
    end

    // Requiring SCL high on both samples rejects simultaneous SCL/SDA changes.
    assign w_start_cond = r_scl_p & w_scl_f &  r_sda_p & ~w_sda_f;
    assign w_stop_cond  = r_scl_p & w_scl_f & ~r_sda_p &  w_sda_f;
    assign w_both_high  = w_scl_f & w_sda_f;

    // STOP excluded explicitly so the pulses stay exclusive even at
    // IDLE_TIMEOUT=1, where the counter threshold is zero.
    assign w_to_hit = TO_EN && (r_state == ST_BUSY) && w_both_high
                      && (r_to_cnt == TO_LAST) && !w_stop_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (TO_EN && enable && (r_state == ST_BUSY) && w_both_high && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_rep_nxt   = 1'b0;
        w_stop_nxt  = 1'b0;
        w_to_nxt    = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_cond) begin
                        w_start_nxt = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else if (w_stop_cond) begin
                        w_stop_nxt = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_start_cond) begin
                        w_rep_nxt = 1'b1;
                    end else if (w_stop_cond) begin
                        w_stop_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_to_hit) begin
                        w_to_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_rep   <= 1'b0;
            r_stop  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_rep   <= w_rep_nxt;
            r_stop  <= w_stop_nxt;
            r_to    <= w_to_nxt;
        end
    end

    assign scl_f     = w_scl_f;
    assign sda_f     = w_sda_f;
    assign start     = r_start;
    assign rep_start = r_rep;
    assign stop      = r_stop;
    assign timeout   = r_to;
    assign bus_busy  = (r_state == ST_BUSY);

endmodule

// File: tb/tb_i2c_bus_cond_detector.sv
module tb_i2c_bus_cond_detector;

    logic clk, rst_n, enable, scl, sda;
    logic scl_f, sda_f, start, rep_start, stop, bus_busy, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state: cycle = number of rising edges seen so far.
    int cyc = 0;
    int n_start = 0, n_rep = 0, n_stop = 0, n_to = 0, n_multi = 0, n_sda_low = 0;
    int c_start = -1, c_rep = -1, c_stop = -1, c_to = -1;
    int b_start, b_rep, b_stop, b_to, b_low;
    int t0, t1, t2, t3, t5, t6, t8, t9, t10;

    i2c_bus_cond_detector #(
        .SYNC_STAGES  (2),
        .FILT_LEN     (3),
        .IDLE_TIMEOUT (10),
        .TO_W         (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .scl       (scl),
        .sda       (sda),
        .scl_f     (scl_f),
        .sda_f     (sda_f),
        .start     (start),
        .rep_start (rep_start),
        .stop      (stop),
        .bus_busy  (bus_busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (start === 1'b1)     begin n_start++; c_start = cyc; end
        if (rep_start === 1'b1) begin n_rep++;   c_rep   = cyc; end
        if (stop === 1'b1)      begin n_stop++;  c_stop  = cyc; end
        if (timeout === 1'b1)   begin n_to++;    c_to    = cyc; end
        if ((int'(start === 1'b1) + int'(rep_start === 1'b1) +
             int'(stop === 1'b1) + int'(timeout === 1'b1)) > 1) n_multi++;
        if (sda_f !== 1'b1) n_sda_low++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_start = n_start;
        b_rep   = n_rep;
        b_stop  = n_stop;
        b_to    = n_to;
        b_low   = n_sda_low;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        scl    = 1'b1;
        sda    = 1'b1;
        clks(3);
        chk("rst_scl_f", 32'(scl_f), 1);
        chk("rst_sda_f", 32'(sda_f), 1);
        chk("rst_busy", 32'(bus_busy), 0);
        chk("rst_pulses", 32'({start, rep_start, stop, timeout}), 0);
        rst_n = 1'b1;
        clks(10);

        // START from idle: pulse on the 6th edge after the SDA fall.
        snap();
        sda = 1'b0; t0 = cyc;
        clks(5);
        chk("t1_busy_before", 32'(bus_busy), 0);
        chk("t1_no_early_start", n_start - b_start, 0);
        clks(15);
        scl = 1'b0;
        clks(5);
        chk("t1_start_count", n_start - b_start, 1);
        chk("t1_start_edge", c_start, t0 + 6);
        chk("t1_no_rep", n_rep - b_rep, 0);
        chk("t1_busy", 32'(bus_busy), 1);

        // Repeated START, then STOP.
        sda = 1'b1; clks(2);
        scl = 1'b1; clks(2);
        snap();
        sda = 1'b0; t1 = cyc;
        clks(10);
        chk("t2_rep_count", n_rep - b_rep, 1);
        chk("t2_rep_edge", c_rep, t1 + 6);
        chk("t2_no_start", n_start - b_start, 0);
        chk("t2_busy", 32'(bus_busy), 1);
        snap();
        sda = 1'b1; t2 = cyc;
        clks(10);
        chk("t2_stop_count", n_stop - b_stop, 1);
        chk("t2_stop_edge", c_stop, t2 + 6);
        chk("t2_idle", 32'(bus_busy), 0);
        chk("t2_no_timeout", n_to - b_to, 0);

        // 2-clk SDA glitch is filtered out entirely.
        snap();
        sda = 1'b0; clks(2);
        sda = 1'b1; clks(10);
        chk("t3_glitch2_sda_f", n_sda_low - b_low, 0);
        chk("t3_glitch2_start", n_start - b_start, 0);
        chk("t3_glitch2_stop", n_stop - b_stop, 0);

        // 3-clk glitch passes: START at +6, STOP at +9.
        snap();
        sda = 1'b0; t3 = cyc;
        clks(3);
        sda = 1'b1;
        clks(10);
        chk("t3_glitch3_start", n_start - b_start, 1);
        chk("t3_glitch3_start_edge", c_start, t3 + 6);
        chk("t3_glitch3_stop", n_stop - b_stop, 1);
        chk("t3_glitch3_stop_edge", c_stop, t3 + 9);
        chk("t3_glitch3_idle", 32'(bus_busy), 0);

        // Simultaneous SCL/SDA changes are neither START nor STOP.
        snap();
        scl = 1'b0; sda = 1'b0;
        clks(10);
        chk("t4_fall_start", n_start - b_start, 0);
        chk("t4_fall_busy", 32'(bus_busy), 0);
        scl = 1'b1; sda = 1'b1;
        clks(10);
        chk("t4_rise_stop", n_stop - b_stop, 0);
        chk("t4_rise_start", n_start - b_start, 0);
        chk("t4_rise_busy", 32'(bus_busy), 0);

        // Timeout: SDA released under SCL low, then SCL released.
        snap();
        sda = 1'b0; t5 = cyc;
        clks(8);
        chk("t5_start_edge", c_start, t5 + 6);
        scl = 1'b0; clks(4);
        sda = 1'b1; clks(4);
        scl = 1'b1; t6 = cyc;
        clks(9);
        chk("t5_no_early_timeout", n_to - b_to, 0);
        chk("t5_busy_before", 32'(bus_busy), 1);
        clks(10);
        chk("t5_timeout_count", n_to - b_to, 1);
        chk("t5_timeout_edge", c_to, t6 + 15);
        chk("t5_no_stop", n_stop - b_stop, 0);
        chk("t5_idle", 32'(bus_busy), 0);

        // Reset mid-transfer.
        snap();
        sda = 1'b0;
        clks(10);
        chk("t6_busy", 32'(bus_busy), 1);
        scl = 1'b0;
        clks(3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus_busy), 0);
        chk("t6_rst_scl_f", 32'(scl_f), 1);
        chk("t6_rst_sda_f", 32'(sda_f), 1);
        chk("t6_rst_pulses", 32'({start, rep_start, stop, timeout}), 0);
        scl = 1'b1; sda = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(10);
        snap();
        sda = 1'b0; t8 = cyc;
        clks(10);
        chk("t6_post_start", n_start - b_start, 1);
        chk("t6_post_start_edge", c_start, t8 + 6);
        chk("t6_post_no_rep", n_rep - b_rep, 0);
        chk("t6_post_busy", 32'(bus_busy), 1);

        // Enable dropped while busy; conditions ignored while disabled.
        enable = 1'b0;
        clks(1);
        chk("t7_disable_busy", 32'(bus_busy), 0);
        scl = 1'b0; clks(2);
        sda = 1'b1; clks(2);
        scl = 1'b1; clks(8);
        snap();
        sda = 1'b0;
        clks(10);
        chk("t7_dis_no_start", n_start - b_start, 0);
        chk("t7_dis_no_rep", n_rep - b_rep, 0);
        chk("t7_dis_sda_f", 32'(sda_f), 0);
        chk("t7_dis_busy", 32'(bus_busy), 0);
        sda = 1'b1;
        clks(10);
        chk("t7_dis_no_stop", n_stop - b_stop, 0);
        enable = 1'b1;
        clks(3);
        snap();
        sda = 1'b0; t9 = cyc;
        clks(10);
        chk("t7_reen_start", n_start - b_start, 1);
        chk("t7_reen_start_edge", c_start, t9 + 6);
        chk("t7_reen_busy", 32'(bus_busy), 1);
        snap();
        sda = 1'b1; t10 = cyc;
        clks(10);
        chk("t7_final_stop_edge", c_stop, t10 + 6);
        chk("t7_final_idle", 32'(bus_busy), 0);

        chk("exclusive_pulses", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
